// File: rtl/axi_read_arbiter.sv
// Two-master AXI-lite read arbiter with one outstanding read, round-robin or fixed priority,
// and a response watchdog that returns an error word and latches a sticky fault flag.
module axi_read_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter logic [15:0] TIMEOUT    = 16'd1024,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s0_araddr,
    input  logic        s0_arvalid,
    output logic        s0_arready,
    output logic [31:0] s0_rdata,
    output logic        s0_rvalid,
    input  logic        s0_rready,
    input  logic [31:0] s1_araddr,
    input  logic        s1_arvalid,
    output logic        s1_arready,
    output logic [31:0] s1_rdata,
    output logic        s1_rvalid,
    input  logic        s1_rready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic        timeout_err
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, ERR, HALT} state_t;

    state_t      state_q;
    logic        grant_q;
    logic        last_q;
    logic [15:0] wdog_q;
    logic        terr_q;
    logic        grant_d;

    // A tie goes to s0 under fixed priority, otherwise to whoever was not served last.
    always_comb begin
        grant_d = s1_arvalid;
        if (s0_arvalid && s1_arvalid) begin
            grant_d = FIXED_PRIO ? 1'b0 : ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            wdog_q  <= 16'd0;
            terr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s0_arvalid || s1_arvalid) begin
                        grant_q <= grant_d;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        wdog_q  <= 16'd0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid) begin
                        if (m_rready) begin
                            last_q  <= grant_q;
                            state_q <= IDLE;
                        end
                    end else if ((TIMEOUT != 16'd0) && (wdog_q == TIMEOUT - 16'd1)) begin
                        terr_q  <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
                ERR: begin
                    if (grant_q ? s1_rready : s0_rready) begin
                        state_q <= HALT;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Channel muxing is decoded from the state register; only the granted port ever sees traffic.
    always_comb begin
        s0_arready  = 1'b0;
        s0_rdata    = 32'd0;
        s0_rvalid   = 1'b0;
        s1_arready  = 1'b0;
        s1_rdata    = 32'd0;
        s1_rvalid   = 1'b0;
        m_araddr    = 32'd0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        timeout_err = terr_q;
        case (state_q)
            ADDR: begin
                m_arvalid = 1'b1;
                if (grant_q) begin
                    m_araddr   = s1_araddr;
                    s1_arready = m_arready;
                end else begin
                    m_araddr   = s0_araddr;
                    s0_arready = m_arready;
                end
            end
            DATA: begin
                if (grant_q) begin
                    m_rready  = s1_rready;
                    s1_rvalid = m_rvalid;
                    s1_rdata  = m_rdata;
                end else begin
                    m_rready  = s0_rready;
                    s0_rvalid = m_rvalid;
                    s0_rdata  = m_rdata;
                end
            end
            ERR: begin
                if (grant_q) begin
                    s1_rvalid = 1'b1;
                    s1_rdata  = ERR_DATA;
                end else begin
                    s0_rvalid = 1'b1;
                    s0_rdata  = ERR_DATA;
                end
            end
            HALT:    m_rready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: instance a is round-robin with TIMEOUT=8,
// instance b is fixed-priority with the watchdog disabled.
module tb_axi_read_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] a_s0_araddr, a_s1_araddr, a_m_rdata;
    logic        a_s0_arvalid, a_s0_rready, a_s1_arvalid, a_s1_rready, a_m_arready, a_m_rvalid;
    logic [31:0] a_s0_rdata, a_s1_rdata, a_m_araddr;
    logic        a_s0_arready, a_s0_rvalid, a_s1_arready, a_s1_rvalid, a_m_arvalid, a_m_rready, a_timeout_err;

    logic [31:0] b_s0_araddr, b_s1_araddr, b_m_rdata;
    logic        b_s0_arvalid, b_s0_rready, b_s1_arvalid, b_s1_rready, b_m_arready, b_m_rvalid;
    logic [31:0] b_s0_rdata, b_s1_rdata, b_m_araddr;
    logic        b_s0_arready, b_s0_rvalid, b_s1_arready, b_s1_rvalid, b_m_arvalid, b_m_rready, b_timeout_err;

    // {s0_arready, s0_rvalid, s1_arready, s1_rvalid, m_arvalid, m_rready}
    wire [5:0] a_ctl = {a_s0_arready, a_s0_rvalid, a_s1_arready, a_s1_rvalid, a_m_arvalid, a_m_rready};
    wire [5:0] b_ctl = {b_s0_arready, b_s0_rvalid, b_s1_arready, b_s1_rvalid, b_m_arvalid, b_m_rready};

    axi_read_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(16'd8), .ERR_DATA(32'hDEAD_BEEF)) dut_a (
        .clk(clk), .rst(rst),
        .s0_araddr(a_s0_araddr), .s0_arvalid(a_s0_arvalid), .s0_arready(a_s0_arready),
        .s0_rdata(a_s0_rdata), .s0_rvalid(a_s0_rvalid), .s0_rready(a_s0_rready),
        .s1_araddr(a_s1_araddr), .s1_arvalid(a_s1_arvalid), .s1_arready(a_s1_arready),
        .s1_rdata(a_s1_rdata), .s1_rvalid(a_s1_rvalid), .s1_rready(a_s1_rready),
        .m_araddr(a_m_araddr), .m_arvalid(a_m_arvalid), .m_arready(a_m_arready),
        .m_rdata(a_m_rdata), .m_rvalid(a_m_rvalid), .m_rready(a_m_rready),
        .timeout_err(a_timeout_err)
    );

    axi_read_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(16'd0), .ERR_DATA(32'hDEAD_BEEF)) dut_b (
        .clk(clk), .rst(rst),
        .s0_araddr(b_s0_araddr), .s0_arvalid(b_s0_arvalid), .s0_arready(b_s0_arready),
        .s0_rdata(b_s0_rdata), .s0_rvalid(b_s0_rvalid), .s0_rready(b_s0_rready),
        .s1_araddr(b_s1_araddr), .s1_arvalid(b_s1_arvalid), .s1_arready(b_s1_arready),
        .s1_rdata(b_s1_rdata), .s1_rvalid(b_s1_rvalid), .s1_rready(b_s1_rready),
        .m_araddr(b_m_araddr), .m_arvalid(b_m_arvalid), .m_arready(b_m_arready),
        .m_rdata(b_m_rdata), .m_rvalid(b_m_rvalid), .m_rready(b_m_rready),
        .timeout_err(b_timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        {a_s0_arvalid, a_s0_rready, a_s1_arvalid, a_s1_rready, a_m_arready, a_m_rvalid} = '0;
        {b_s0_arvalid, b_s0_rready, b_s1_arvalid, b_s1_rready, b_m_arready, b_m_rvalid} = '0;
        a_s0_araddr = 0; a_s1_araddr = 0; a_m_rdata = 0;
        b_s0_araddr = 0; b_s1_araddr = 0; b_m_rdata = 0;
        tick();
        do_reset();
        n_tests++;
        if ({a_ctl, a_timeout_err} !== 7'd0) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 0000000", {a_ctl, a_timeout_err});
        end
        // IDLE must stay silent even with live inputs.
        a_s0_arvalid = 1'b1; a_s0_araddr = 32'h0000_0F00; a_m_rvalid = 1'b1; a_m_rdata = 32'hCAFE_0001;
        a_s0_rready = 1'b1; a_m_arready = 1'b1;
        #1;
        n_tests++;
        if ({a_ctl, a_s0_rdata, a_s1_rdata, a_m_araddr} !== {6'd0, 96'd0}) begin
            n_fail++; $display("FAIL idle_quiet: ctl %b s0_rdata %h m_araddr %h expected all 0", a_ctl, a_s0_rdata, a_m_araddr);
        end
        a_s0_arvalid = 1'b0; a_m_rvalid = 1'b0; a_m_rdata = 0; a_s0_rready = 1'b0;
    endtask

    task automatic test_single_s0();
        a_s0_arvalid = 1'b1; a_s0_araddr = 32'h0000_0010; a_m_arready = 1'b1; a_s0_rready = 1'b1;
        #1;
        n_tests++;
        if (a_ctl !== 6'b000000) begin n_fail++; $display("FAIL single_c0: got %b expected 000000", a_ctl); end
        tick();
        n_tests++;
        if ({a_ctl, a_m_araddr} !== {6'b100010, 32'h0000_0010}) begin
            n_fail++; $display("FAIL single_addr: got %b %h expected 100010 00000010", a_ctl, a_m_araddr);
        end
        tick();
        a_s0_arvalid = 1'b0;
        #1;
        n_tests++;
        if (a_ctl !== 6'b000001) begin n_fail++; $display("FAIL single_wait: got %b expected 000001", a_ctl); end
        tick();
        a_m_rvalid = 1'b1; a_m_rdata = 32'h1234_5678;
        #1;
        n_tests++;
        if ({a_ctl, a_s0_rdata, a_s1_rdata} !== {6'b010001, 32'h1234_5678, 32'd0}) begin
            n_fail++; $display("FAIL single_data: got %b %h %h expected 010001 12345678 00000000", a_ctl, a_s0_rdata, a_s1_rdata);
        end
        tick();
        a_m_rvalid = 1'b0;
        #1;
        n_tests++;
        if (a_ctl !== 6'b000000) begin n_fail++; $display("FAIL single_idle: got %b expected 000000", a_ctl); end
    endtask

    task automatic test_round_robin();
        do_reset();
        a_s0_arvalid = 1'b1; a_s0_araddr = 32'h0000_0100; a_s0_rready = 1'b1;
        a_s1_arvalid = 1'b1; a_s1_araddr = 32'h1000_0004; a_s1_rready = 1'b1;
        a_m_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ((i % 2) == 0) begin
                if ({a_ctl, a_m_araddr} !== {6'b100010, 32'h0000_0100}) begin
                    n_fail++; $display("FAIL rr_addr%0d: got %b %h expected 100010 00000100", i, a_ctl, a_m_araddr);
                end
            end else begin
                if ({a_ctl, a_m_araddr} !== {6'b001010, 32'h1000_0004}) begin
                    n_fail++; $display("FAIL rr_addr%0d: got %b %h expected 001010 10000004", i, a_ctl, a_m_araddr);
                end
            end
            tick();
            a_m_rvalid = 1'b1; a_m_rdata = 32'hA0 + i;
            #1;
            n_tests++;
            if ((i % 2) == 0) begin
                if ({a_ctl, a_s0_rdata} !== {6'b010001, 32'hA0 + i}) begin
                    n_fail++; $display("FAIL rr_data%0d: got %b %h expected 010001 %h", i, a_ctl, a_s0_rdata, 32'hA0 + i);
                end
            end else begin
                if ({a_ctl, a_s1_rdata} !== {6'b000101, 32'hA0 + i}) begin
                    n_fail++; $display("FAIL rr_data%0d: got %b %h expected 000101 %h", i, a_ctl, a_s1_rdata, 32'hA0 + i);
                end
            end
            tick();
            a_m_rvalid = 1'b0;
        end
        a_s0_arvalid = 1'b0; a_s1_arvalid = 1'b0; a_s0_rready = 1'b0; a_s1_rready = 1'b0;
    endtask

    task automatic test_fixed_prio();
        b_s0_arvalid = 1'b1; b_s0_araddr = 32'h0000_0200; b_s0_rready = 1'b1;
        b_s1_arvalid = 1'b1; b_s1_araddr = 32'h1000_0008; b_s1_rready = 1'b1;
        b_m_arready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if ({b_ctl, b_m_araddr} !== {6'b100010, 32'h0000_0200}) begin
                n_fail++; $display("FAIL fp_s0_%0d: got %b %h expected 100010 00000200", i, b_ctl, b_m_araddr);
            end
            tick();
            if (i == 1) b_s0_arvalid = 1'b0;
            b_m_rvalid = 1'b1;
            tick();
            b_m_rvalid = 1'b0;
        end
        tick();
        n_tests++;
        if ({b_ctl, b_m_araddr} !== {6'b001010, 32'h1000_0008}) begin
            n_fail++; $display("FAIL fp_s1: got %b %h expected 001010 10000008", b_ctl, b_m_araddr);
        end
        tick();
        b_s1_arvalid = 1'b0; b_m_rvalid = 1'b1;
        tick();
        b_m_rvalid = 1'b0;
    endtask

    task automatic test_backpressure();
        a_s1_arvalid = 1'b1; a_s1_araddr = 32'h2000_0008; a_s1_rready = 1'b0; a_m_arready = 1'b1;
        tick();
        n_tests++;
        if (a_ctl !== 6'b001010) begin n_fail++; $display("FAIL bp_addr: got %b expected 001010", a_ctl); end
        tick();
        a_s1_arvalid = 1'b0;
        for (int j = 0; j < 6; j++) tick();
        a_m_rvalid = 1'b1; a_m_rdata = 32'h4000_00AA;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_tests++;
            if ({a_ctl, a_s1_rdata, a_timeout_err} !== {6'b000100, 32'h4000_00AA, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold%0d: got %b %h %b expected 000100 400000aa 0", j, a_ctl, a_s1_rdata, a_timeout_err);
            end
            tick();
        end
        a_s1_rready = 1'b1;
        #1;
        n_tests++;
        if (a_ctl !== 6'b000101) begin n_fail++; $display("FAIL bp_hs: got %b expected 000101", a_ctl); end
        tick();
        a_m_rvalid = 1'b0; a_s1_rready = 1'b0;
        #1;
        n_tests++;
        if ({a_ctl, a_timeout_err} !== 7'd0) begin
            n_fail++; $display("FAIL bp_done: got %b expected 0000000", {a_ctl, a_timeout_err});
        end
    endtask

    task automatic test_timeout();
        a_s1_arvalid = 1'b1; a_s1_araddr = 32'h3000_0000; a_s1_rready = 1'b0; a_m_rvalid = 1'b0;
        tick();
        tick();
        a_s1_arvalid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            #1;
            n_tests++;
            if ({a_ctl, a_timeout_err} !== 7'd0) begin
                n_fail++; $display("FAIL to_wait%0d: got %b expected 0000000", j, {a_ctl, a_timeout_err});
            end
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            n_tests++;
            if ({a_ctl, a_s1_rdata, a_timeout_err} !== {6'b000100, 32'hDEAD_BEEF, 1'b1}) begin
                n_fail++; $display("FAIL to_err%0d: got %b %h %b expected 000100 deadbeef 1", j, a_ctl, a_s1_rdata, a_timeout_err);
            end
            if (j == 0) tick();
        end
        a_s1_rready = 1'b1;
        tick();
        a_s1_rready = 1'b0; a_s0_arvalid = 1'b1; a_s0_araddr = 32'h0000_0040; a_m_arready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_tests++;
            if ({a_ctl, a_timeout_err} !== 7'b0000011) begin
                n_fail++; $display("FAIL halt%0d: got %b expected 0000011", j, {a_ctl, a_timeout_err});
            end
            tick();
        end
        a_m_rvalid = 1'b1; a_m_rdata = 32'h7777_0000;
        #1;
        n_tests++;
        if ({a_ctl, a_s0_rdata, a_s1_rdata} !== {6'b000001, 64'd0}) begin
            n_fail++; $display("FAIL halt_absorb: got %b %h %h expected 000001 0 0", a_ctl, a_s0_rdata, a_s1_rdata);
        end
        tick();
        a_m_rvalid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        a_s0_arvalid = 1'b0;
        do_reset();
        n_tests++;
        if ({a_ctl, a_timeout_err} !== 7'd0) begin
            n_fail++; $display("FAIL rst_halt: got %b expected 0000000", {a_ctl, a_timeout_err});
        end
        a_s0_arvalid = 1'b1; a_s0_araddr = 32'h0000_0030; a_s0_rready = 1'b1; a_m_arready = 1'b1;
        tick();
        tick();
        a_s0_arvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; a_m_rvalid = 1'b1; a_m_rdata = 32'h9999_0000;
        #1;
        n_tests++;
        if ({a_ctl, a_s0_rdata} !== {6'd0, 32'd0}) begin
            n_fail++; $display("FAIL rst_data: got %b %h expected 000000 00000000", a_ctl, a_s0_rdata);
        end
        a_m_rvalid = 1'b0;
        a_s0_arvalid = 1'b1;
        tick();
        n_tests++;
        if ({a_ctl, a_m_araddr} !== {6'b100010, 32'h0000_0030}) begin
            n_fail++; $display("FAIL rst_new_addr: got %b %h expected 100010 00000030", a_ctl, a_m_araddr);
        end
        tick();
        a_s0_arvalid = 1'b0; a_m_rvalid = 1'b1; a_m_rdata = 32'h5555_AAAA;
        #1;
        n_tests++;
        if ({a_ctl, a_s0_rdata} !== {6'b010001, 32'h5555_AAAA}) begin
            n_fail++; $display("FAIL rst_new_data: got %b %h expected 010001 5555aaaa", a_ctl, a_s0_rdata);
        end
        tick();
        a_m_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_s0();
        test_round_robin();
        test_fixed_prio();
        test_backpressure();
        test_timeout();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
